// File: rtl/flash_pkg.sv
// Shared constants and FSM state encoding for the flash byte-strobe receiver.
package flash_pkg;
  localparam int FLASH_DW = 8;
  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {
    ST_ARM_WAIT = 2'd0,
    ST_IDLE     = 2'd1,
    ST_HIGH     = 2'd2
  } flash_state_e;
endpackage

// File: rtl/flash_fifo.sv
// Small power-of-2 FIFO with a registered head; a pushed byte becomes visible
// on dout_o one cycle after it is written.
module flash_fifo
  import flash_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = FLASH_DW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [DW-1:0]            din_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            dout_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          full_s, pop_s, push_s;

  // Pointer/level next state; head is refreshed only from entries present before this edge.
  always_comb begin
    full_s   = (level_q == LW'(DEPTH));
    pop_s    = pop_i & valid_q;
    push_s   = push_i & (~full_s | pop_s);
    wr_ptr_d = wr_ptr_q + AW'(push_s);
    rd_ptr_d = rd_ptr_q + AW'(pop_s);
    level_d  = level_q + LW'(push_s) - LW'(pop_s);
    valid_d  = ((level_q - LW'(pop_s)) != '0);
    if (valid_d) begin
      dout_d = mem_q[rd_ptr_d];
    end else begin
      dout_d = dout_q;
    end
  end

  // Storage, pointers and registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= din_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
    end
  end

  assign dout_o  = dout_q;
  assign valid_o = valid_q;
  assign full_o  = full_s;
  assign level_o = level_q;
endmodule

// File: rtl/flash_capture.sv
// Flash strobe receiver: one byte per strobe into a FIFO, sticky overflow/stuck flags.
// Optional FLASH_CAPTURE_COUNT_EN adds a cap_count output of accepted bytes.
module flash_capture
  import flash_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MAX_HIGH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [FLASH_DW-1:0]    datastream,
  input  logic                   flashin,
  input  logic                   clr_err,
  output logic [FLASH_DW-1:0]    dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic                   overflow,
  output logic                   stuck,
`ifdef FLASH_CAPTURE_COUNT_EN
  output logic [CNT_W-1:0]       cap_count,
`endif
  output logic [$clog2(DEPTH):0] level
);
  localparam int HW = $clog2(MAX_HIGH + 1);

  flash_state_e  state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          overflow_q, overflow_d;
  logic          stuck_q, stuck_d;
  logic          push_s, stuck_set_s, drop_s, accept_s, full_s;

  flash_fifo #(.DEPTH(DEPTH), .DW(FLASH_DW)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push_s),
    .din_i   (datastream),
    .pop_i   (dout_ready),
    .dout_o  (dout),
    .valid_o (dout_valid),
    .full_o  (full_s),
    .level_o (level)
  );

  // Strobe FSM: capture on entry to HIGH, count high cycles, re-arm after a stuck strobe.
  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    push_s      = 1'b0;
    stuck_set_s = 1'b0;
    case (state_q)
      ST_ARM_WAIT: begin
        if (!flashin) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ARM_WAIT;
        end
      end
      ST_IDLE: begin
        if (flashin) begin
          push_s  = 1'b1;
          hcnt_d  = HW'(1);
          state_d = ST_HIGH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HIGH: begin
        if (!flashin) begin
          hcnt_d  = '0;
          state_d = ST_IDLE;
        end else if (hcnt_q == HW'(MAX_HIGH - 1)) begin
          stuck_set_s = 1'b1;
          hcnt_d      = '0;
          state_d     = ST_ARM_WAIT;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      default: begin
        hcnt_d  = '0;
        state_d = ST_ARM_WAIT;
      end
    endcase
  end

  // Sticky flags: a fresh error in the clearing cycle keeps the flag set.
  always_comb begin
    drop_s   = push_s & full_s & ~(dout_valid & dout_ready);
    accept_s = push_s & ~drop_s;
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (clr_err) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    if (stuck_set_s) begin
      stuck_d = 1'b1;
    end else if (clr_err) begin
      stuck_d = 1'b0;
    end else begin
      stuck_d = stuck_q;
    end
  end

  // FSM, strobe counter and flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_ARM_WAIT;
      hcnt_q     <= '0;
      overflow_q <= 1'b0;
      stuck_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      overflow_q <= overflow_d;
      stuck_q    <= stuck_d;
    end
  end

  assign overflow = overflow_q;
  assign stuck    = stuck_q;

`ifdef FLASH_CAPTURE_COUNT_EN
  logic [CNT_W-1:0] cap_count_q, cap_count_d;

  // Accepted-byte counter; clearing restarts from this cycle's accepted byte.
  always_comb begin
    if (clr_err) begin
      cap_count_d = CNT_W'(accept_s);
    end else begin
      cap_count_d = cap_count_q + CNT_W'(accept_s);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_count_q <= '0;
    end else begin
      cap_count_q <= cap_count_d;
    end
  end

  assign cap_count = cap_count_q;
`else
  logic unused_accept_s;
  assign unused_accept_s = accept_s;
`endif
endmodule

// File: tb/tb_flash_capture.sv
// Randomized self-checking bench for flash_capture with a queue-based reference model.
module tb_flash_capture;
  localparam int DEPTH    = 4;
  localparam int MAX_HIGH = 8;
  localparam int LW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    datastream = 8'h00;
  logic          flashin = 1'b0;
  logic          clr_err = 1'b0;
  logic          dout_ready = 1'b0;
  logic [7:0]    dout;
  logic          dout_valid;
  logic          overflow;
  logic          stuck;
  logic [LW-1:0] level;
`ifdef FLASH_CAPTURE_COUNT_EN
  logic [15:0]   cap_count;
`endif

  flash_capture #(.DEPTH(DEPTH), .MAX_HIGH(MAX_HIGH)) dut (
    .clk        (clk),
    .reset      (reset),
    .datastream (datastream),
    .flashin    (flashin),
    .clr_err    (clr_err),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overflow   (overflow),
    .stuck      (stuck),
`ifdef FLASH_CAPTURE_COUNT_EN
    .cap_count  (cap_count),
`endif
    .level      (level)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of stored bytes plus visible-head state.
  logic [7:0] mq[$];
  logic       m_valid, m_ovf, m_stk, m_prev;
  logic [7:0] m_dout;
  int         m_run, m_cnt;
  logic       rand_mode = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_valid = 1'b0; m_ovf = 1'b0; m_stk = 1'b0;
    m_prev  = 1'b1;  // a strobe already high at release must not capture
    m_dout  = 8'h00; m_run = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic pop, rise, nv, ovf_set, stk_set, acc;
    int sz;
    pop  = m_valid && dout_ready;
    rise = flashin && !m_prev;
    sz   = mq.size();
    nv   = (sz - (pop ? 1 : 0)) > 0;
    ovf_set = 1'b0; acc = 1'b0; stk_set = 1'b0;
    if (pop) void'(mq.pop_front());
    if (rise) begin
      if (sz == DEPTH && !pop) ovf_set = 1'b1;
      else begin mq.push_back(datastream); acc = 1'b1; end
      m_run = 1;
    end else if (flashin && m_run > 0) begin
      m_run++;
      if (m_run == MAX_HIGH) stk_set = 1'b1;
    end else if (!flashin) begin
      m_run = 0;
    end
    m_ovf  = ovf_set ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
    m_stk  = stk_set ? 1'b1 : (clr_err ? 1'b0 : m_stk);
    m_cnt  = clr_err ? int'(acc) : ((m_cnt + int'(acc)) & 16'hFFFF);
    m_prev = flashin;
    m_valid = nv;
    if (nv) m_dout = mq[0];
  endtask

  task automatic check_outputs();
    check("valid", 32'(dout_valid), 32'(m_valid));
    if (m_valid) check("dout", 32'(dout), 32'(m_dout));
    check("level", 32'(level), 32'(mq.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("stuck", 32'(stuck), 32'(m_stk));
`ifdef FLASH_CAPTURE_COUNT_EN
    check("cap_count", 32'(cap_count), 32'(m_cnt));
`endif
  endtask

  task automatic cycle();
    if (rand_mode) begin
      dout_ready = ($urandom_range(0, 1) == 1);
      clr_err    = ($urandom_range(0, 19) == 0);
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic strobe(input logic [7:0] data, input int hi_len, input int gap);
    datastream = data;
    flashin    = 1'b1;
    repeat (hi_len) cycle();
    flashin = 1'b0;
    repeat (gap) cycle();
  endtask

  initial begin
    model_reset();
    flashin = 1'b1; datastream = 8'hAA;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    // strobe high across reset release: ignored
    repeat (3) cycle();
    check("t1_no_capture", 32'(level), 32'd0);
    flashin = 1'b0;
    cycle();
    strobe(8'h5A, 1, 0);
    check("t1_latency_valid", 32'(dout_valid), 32'd0);
    cycle();
    check("t1_valid", 32'(dout_valid), 32'd1);
    check("t1_dout", 32'(dout), 32'h5A);
    dout_ready = 1'b1;
    cycle();
    dout_ready = 1'b0;

    for (int i = 1; i <= 4; i++) strobe(8'(i), 1, 2);
    check("t2_level", 32'(level), 32'd4);
    check("t2_no_ovf", 32'(overflow), 32'd0);
    strobe(8'h05, 1, 2);
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_head", 32'(dout), 32'h01);
    clr_err = 1'b1; cycle(); clr_err = 1'b0;
    check("t3_clr", 32'(overflow), 32'd0);

    dout_ready = 1'b1;
    strobe(8'h05, 1, 0);
    dout_ready = 1'b0;
    cycle();
    check("t4_level", 32'(level), 32'd4);
    check("t4_no_ovf", 32'(overflow), 32'd0);
    dout_ready = 1'b1;
    repeat (6) cycle();
    dout_ready = 1'b0;

    strobe(8'h77, 8, 3);
    check("t5_stuck", 32'(stuck), 32'd1);
    check("t5_one_byte", 32'(level), 32'd1);
    strobe(8'h66, 11, 3);
    check("t5_rearm", 32'(level), 32'd2);
    clr_err = 1'b1; cycle(); clr_err = 1'b0;

    rand_mode = 1'b1;
    for (int n = 0; n < 300; n++) begin
      int hl;
      hl = ($urandom_range(0, 9) == 0) ? $urandom_range(2, 10) : 1;
      strobe(8'($urandom), hl, $urandom_range(2, 5));
    end
    rand_mode = 1'b0;
    clr_err = 1'b0;

    dout_ready = 1'b1;
    repeat (8) cycle();
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) strobe(8'($urandom), 1, 2);
    check("t6_pre_level", 32'(level), 32'd3);
    flashin = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("t6_dout", 32'(dout), 32'd0);
    check("t6_valid", 32'(dout_valid), 32'd0);
    check("t6_level", 32'(level), 32'd0);
    check("t6_flags", 32'({overflow, stuck}), 32'd0);
`ifdef FLASH_CAPTURE_COUNT_EN
    check("t6_count", 32'(cap_count), 32'd0);
`endif
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) cycle();
    flashin = 1'b0;
    cycle();
    strobe(8'hC3, 1, 3);
    check("t6_after", 32'(dout), 32'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
